// File: rtl/regfile_dump_tx_if.sv
// rtl/regfile_dump_tx_if.sv - register-file read port, dump control and byte stream bundle
// master: the dump streamer; slave: the register file / byte sink side.
interface regfile_dump_tx_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, rd_data, byte_ready,
    output rd_addr, byte_data, byte_valid, busy, done
  );

  modport slave (
    output start, rd_data, byte_ready,
    input  rd_addr, byte_data, byte_valid, busy, done
  );
endinterface

// File: rtl/regfile_dump_tx.sv
// rtl/regfile_dump_tx.sv - streams every GPR out as LSB-first bytes for post-mortem dumps
// Optional trailing XOR checksum byte: define REGDUMP_CHECKSUM_EN.
module regfile_dump_tx #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  regfile_dump_tx_if.master   bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

`ifdef REGDUMP_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_CSUM, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} state_t;
`endif

  state_t            state;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic [CNT_W-1:0]  byte_cnt;
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              busy;
  logic              done;
  logic              xfer;
  logic              last_byte;
  logic              last_reg;
`ifdef REGDUMP_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign shift_next = shift_reg >> 8;
  assign xfer       = byte_valid & bus.byte_ready;
  assign last_byte  = (byte_cnt == CNT_W'(BYTES - 1));
  assign last_reg   = (rd_addr == ADDR_W'(NUM_REGS - 1));

  assign bus.rd_addr    = rd_addr;
  assign bus.byte_data  = byte_data;
  assign bus.byte_valid = byte_valid;
  assign bus.busy       = busy;
  assign bus.done       = done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      rd_addr    <= '0;
      shift_reg  <= '0;
      byte_cnt   <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          // rd_addr keeps the last dumped address until a new dump begins
          if (bus.start) begin
            state   <= S_LOAD;
            rd_addr <= '0;
            busy    <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
            csum    <= '0;
`endif
          end
        end
        S_LOAD: begin
          // The only cycle rd_data is captured; later register writes cannot tear this word
          shift_reg  <= bus.rd_data;
          byte_data  <= bus.rd_data[7:0];
          byte_valid <= 1'b1;
          byte_cnt   <= '0;
          state      <= S_SEND;
        end
        S_SEND: begin
          if (xfer) begin
            shift_reg <= shift_next;
            byte_cnt  <= byte_cnt + CNT_W'(1);
`ifdef REGDUMP_CHECKSUM_EN
            csum      <= csum ^ byte_data;
`endif
            if (last_byte) begin
              if (last_reg) begin
`ifdef REGDUMP_CHECKSUM_EN
                byte_data  <= csum ^ byte_data;
                state      <= S_CSUM;
`else
                byte_valid <= 1'b0;
                done       <= 1'b1;
                state      <= S_DONE;
`endif
              end else begin
                byte_valid <= 1'b0;
                rd_addr    <= rd_addr + ADDR_W'(1);
                state      <= S_LOAD;
              end
            end else begin
              byte_data <= shift_next[7:0];
            end
          end
        end
`ifdef REGDUMP_CHECKSUM_EN
        S_CSUM: begin
          if (xfer) begin
            byte_valid <= 1'b0;
            done       <= 1'b1;
            state      <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state      <= S_IDLE;
          byte_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end
endmodule
